key_schedule_expand: RTL
========================

KEY_SCHEDULE_EXPAND -- requirements
Module: key_schedule_expand

Interface
- REQ-001 SHALL have parameter ROW_STRIDE, default 120, giving the word-memory address distance between byte rows.
- REQ-002 SHALL have parameter RCON_INIT, default 8'h01, giving the first round constant.
- REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock.
- REQ-004 SHALL have port ap_rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have ports ap_start (input), ap_done, ap_idle and ap_ready (outputs), 1 bit each: ap_ctrl_hs block handshake.
- REQ-006 SHALL have key_address0 (output, 5 bits), key_ce0 (output, 1 bit) and key_q0 (input, 32 bits): key byte ROM port with 1-cycle read latency; key byte index = 4*col + row.
- REQ-007 SHALL have sbox_address0/1 (output, 8 bits), sbox_ce0/1 (output, 1 bit) and sbox_q0/1 (input, 32 bits): dual S-box ROM ports with 1-cycle latency.
- REQ-008 SHALL have word_address0/1 (output, 9 bits), word_ce0/1, word_we0/1 (output, 1 bit) and word_d0/1 (output, 32 bits): dual write ports into the round-key memory read by AddRoundKey.

Function
- REQ-009 SHALL place byte (row r, column c) at word address r*ROW_STRIDE + c; data bits [31:8] SHALL be zero; only bits [7:0] of key_q0 and sbox_q0/1 SHALL be used.
- REQ-010 SHALL use FSM states IDLE, KRD, KWR, HEAD, SB0, SB1, SB2, WR0 and WR1.
- REQ-011 IDLE: ap_idle = !ap_start; ap_start high SHALL clear the column and row counters, load rcon with RCON_INIT and go to KRD.
- REQ-012 KRD SHALL issue a key read; KWR SHALL write the byte through port 0, store it in the Nk-column window, advance the row (then the column), and return to KRD until 4*Nk bytes are written, then go to HEAD with i = Nk.
- REQ-013 HEAD with i = 4*(Nr+1) SHALL assert ap_done and ap_ready for one cycle and go to IDLE; otherwise it SHALL go to SB0 if i mod Nk = 0, else to WR0.
- REQ-014 SB0 SHALL issue S-box reads of rotated bytes w[i-1][1] and w[i-1][2] on ports 0/1; SB1 SHALL read w[i-1][3] and w[i-1][0] and capture the first pair; SB2 SHALL capture the second pair and XOR rcon into temp byte 0.
- REQ-015 WR0 SHALL write rows 0 and 1 (ports 0/1) of w[i] = w[i-Nk] ^ temp; WR1 SHALL write rows 2 and 3, shift the window, increment i and return to HEAD.
- REQ-016 After each SubWord column, rcon SHALL update as (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), truncated to 8 bits.
- REQ-017 ce SHALL be high only in cycles that read or write; we only in KWR, WR0 and WR1; addresses SHALL be don't-care otherwise.
- REQ-018 For AES-128, ap_done SHALL be asserted exactly 183 cycles after the IDLE cycle that samples ap_start high.
- REQ-019 ap_start SHALL be ignored outside IDLE; ap_start held high through done SHALL start a new run on the next IDLE cycle.

Reset
- REQ-020 ap_rst SHALL force IDLE, clear counters and window, set rcon = RCON_INIT, and drive ap_done, ap_ready and all ce/we to 0 in the following cycle.
- REQ-021 Reset mid-run SHALL abort with no further memory writes; previously written words SHALL be left untouched.

Configuration
- REQ-022 With KS_AES256_EN defined, SHALL add input nk_sel (1 bit, sampled at start): 0 gives Nk=4, Nr=10; 1 gives Nk=8, Nr=14, a 32-byte key load, and for i mod 8 = 4 a SubWord with no rotation and no rcon (SB0–SB2 reads bytes 0..3 in order).
- REQ-023 Without KS_AES256_EN, nk_sel SHALL be absent and Nk=4, Nr=10 SHALL be fixed.

Verification
- REQ-024 Key 2b7e1516 28aed2a6 abf71588 09cf4f3c, start -> word[4]=0xa0, word[124]=0xfa, word[244]=0xfe, word[364]=0x17; done at cycle 183.
- REQ-025 Same key -> word[43]=0xb6, word[403]=0xa6; no write to any column >= 44.
- REQ-026 AES-256 (macro set, nk_sel=1), key 603deb10...0914dff4 -> w[8]=9ba35411, w[59]=706c631e.
- REQ-027 ap_rst asserted in the 3rd SB1 cycle -> no we in following cycles, ap_idle=1; a fresh start then reproduces REQ-024 results.
- REQ-028 ap_start held high for two runs -> two ap_done pulses separated by 184 cycles; rcon restarts at 0x01.
- REQ-029 ap_start pulsed during HEAD -> ignored; exactly one ap_done pulse.

Source files
------------

// File: rtl/key_schedule_expand.sv
// rtl/key_schedule_expand.sv - AES key expansion writing round-key bytes into a row-strided word memory
// Optional AES-256 support (nk_sel input, Nk=8/Nr=14) is enabled by defining KS_AES256_EN.
module key_schedule_expand #(
  parameter int unsigned ROW_STRIDE = 120,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
`ifdef KS_AES256_EN
  input  logic        nk_sel,
`endif
  output logic [4:0]  key_address0,
  output logic        key_ce0,
  input  logic [31:0] key_q0,
  output logic [7:0]  sbox_address0,
  output logic        sbox_ce0,
  input  logic [31:0] sbox_q0,
  output logic [7:0]  sbox_address1,
  output logic        sbox_ce1,
  input  logic [31:0] sbox_q1,
  output logic [8:0]  word_address0,
  output logic        word_ce0,
  output logic        word_we0,
  output logic [31:0] word_d0,
  output logic [8:0]  word_address1,
  output logic        word_ce1,
  output logic        word_we1,
  output logic [31:0] word_d1
);

  typedef enum logic [3:0] {IDLE, KRD, KWR, HEAD, SB0, SB1, SB2, WR0, WR1} state_t;

  state_t          state_q, state_d;
  logic [5:0]      col_q, col_d;   // key-load column, then reused as word index i
  logic [1:0]      row_q, row_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            nk8_q, nk8_d;
  logic [3:0][7:0] win_q [8];
  logic [3:0][7:0] win_d [8];
  logic [3:0][7:0] temp_q, temp_d;

  logic [2:0]      last_col;
  logic [5:0]      end_col;
  logic            rot_col, sub_col;
  logic [3:0][7:0] prev_w, new_w;
  logic            unused_hi;

  assign unused_hi = ^{key_q0[31:8], sbox_q0[31:8], sbox_q1[31:8]};

  // win_q[0] holds w[i-Nk], win_q[last_col] holds w[i-1]
  always_comb begin
    last_col = nk8_q ? 3'd7 : 3'd3;
    end_col  = nk8_q ? 6'd60 : 6'd44;
    rot_col  = nk8_q ? (col_q[2:0] == 3'd0) : (col_q[1:0] == 2'd0);
    sub_col  = nk8_q && (col_q[2:0] == 3'd4);
    prev_w   = win_q[last_col];
    new_w    = win_q[0] ^ temp_q;
  end

  function automatic logic [8:0] byte_addr(input logic [1:0] r, input logic [5:0] c);
    return 9'(32'(r) * ROW_STRIDE + 32'(c));
  endfunction

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      col_q  <= '0;
      row_q  <= '0;
      rcon_q <= RCON_INIT;
      nk8_q  <= 1'b0;
      temp_q <= '0;
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      rcon_q <= rcon_d;
      nk8_q  <= nk8_d;
      temp_q <= temp_d;
      win_q  <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ap_start) state_d = KRD;
      KRD:  state_d = KWR;
      KWR:  state_d = (row_q == 2'd3 && col_q[2:0] == last_col) ? HEAD : KRD;
      HEAD: begin
        if (col_q == end_col)       state_d = IDLE;
        else if (rot_col || sub_col) state_d = SB0;
        else                        state_d = WR0;
      end
      SB0:  state_d = SB1;
      SB1:  state_d = SB2;
      SB2:  state_d = WR0;
      WR0:  state_d = WR1;
      WR1:  state_d = HEAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    rcon_d = rcon_q;
    nk8_d  = nk8_q;
    temp_d = temp_q;
    win_d  = win_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          col_d  = '0;
          row_d  = '0;
          rcon_d = RCON_INIT;
`ifdef KS_AES256_EN
          nk8_d  = nk_sel;
`else
          nk8_d  = 1'b0;
`endif
        end
      end
      KWR: begin
        win_d[col_q[2:0]][row_q] = key_q0[7:0];
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) col_d = col_q + 6'd1;
      end
      HEAD: if (!(rot_col || sub_col)) temp_d = prev_w;
      SB1: begin
        temp_d[0] = sbox_q0[7:0];
        temp_d[1] = sbox_q1[7:0];
      end
      SB2: begin
        temp_d[2] = sbox_q0[7:0];
        temp_d[3] = sbox_q1[7:0];
        if (rot_col) begin
          temp_d[0] = temp_q[0] ^ rcon_q;
          rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
      end
      WR1: begin
        for (int j = 0; j < 7; j++) if (3'(j) < last_col) win_d[j] = win_q[j+1];
        win_d[last_col] = new_w;
        col_d = col_q + 6'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ap_idle       = 1'b0;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    key_ce0       = 1'b0;
    key_address0  = {col_q[2:0], row_q};
    sbox_ce0      = 1'b0;
    sbox_ce1      = 1'b0;
    sbox_address0 = prev_w[0];
    sbox_address1 = prev_w[1];
    word_ce0      = 1'b0;
    word_we0      = 1'b0;
    word_address0 = byte_addr(row_q, col_q);
    word_d0       = '0;
    word_ce1      = 1'b0;
    word_we1      = 1'b0;
    word_address1 = byte_addr(2'd1, col_q);
    word_d1       = '0;
    case (state_q)
      IDLE: ap_idle = !ap_start;
      KRD:  key_ce0 = 1'b1;
      KWR: begin
        word_ce0 = 1'b1;
        word_we0 = 1'b1;
        word_d0  = {24'd0, key_q0[7:0]};
      end
      HEAD: begin
        ap_done  = (col_q == end_col);
        ap_ready = (col_q == end_col);
      end
      SB0: begin
        sbox_ce0      = 1'b1;
        sbox_ce1      = 1'b1;
        sbox_address0 = rot_col ? prev_w[1] : prev_w[0];
        sbox_address1 = rot_col ? prev_w[2] : prev_w[1];
      end
      SB1: begin
        sbox_ce0      = 1'b1;
        sbox_ce1      = 1'b1;
        sbox_address0 = rot_col ? prev_w[3] : prev_w[2];
        sbox_address1 = rot_col ? prev_w[0] : prev_w[3];
      end
      WR0: begin
        word_ce0      = 1'b1;
        word_we0      = 1'b1;
        word_address0 = byte_addr(2'd0, col_q);
        word_d0       = {24'd0, new_w[0]};
        word_ce1      = 1'b1;
        word_we1      = 1'b1;
        word_address1 = byte_addr(2'd1, col_q);
        word_d1       = {24'd0, new_w[1]};
      end
      WR1: begin
        word_ce0      = 1'b1;
        word_we0      = 1'b1;
        word_address0 = byte_addr(2'd2, col_q);
        word_d0       = {24'd0, new_w[2]};
        word_ce1      = 1'b1;
        word_we1      = 1'b1;
        word_address1 = byte_addr(2'd3, col_q);
        word_d1       = {24'd0, new_w[3]};
      end
      default: ;
    endcase
  end

endmodule
